// File: rtl/lsu.sv
// Load/store unit: registers execute results to writeback and runs one outstanding
// data-memory transaction with lane steering. Optional macro: LSU_MISALIGN_TRAP_EN.
module lsu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_w_reg_enable_i,
    input  logic              mem_w_reg_enable_i,
    input  logic [4:0]        w_reg_addr_i,
    input  logic [DATA_W-1:0] ex_w_reg_data_i,
    input  logic              r_mem_enable_i,
    input  logic [ADDR_W-1:0] r_mem_addr_i,
    input  logic              w_mem_enable_i,
    input  logic [ADDR_W-1:0] w_mem_addr_i,
    input  logic [DATA_W-1:0] w_mem_data_i,
    input  logic [2:0]        data_type_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_wstrb_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              w_reg_enable_o,
    output logic [4:0]        w_reg_addr_o,
    output logic [DATA_W-1:0] w_reg_data_o,
    output logic              stall_o,
    output logic              misalign_o
);

    // data_type_bus encoding: no=0, byte=1, half=2, word=3, ubyte=4, uhalf=5
    typedef enum logic [2:0] {
        DT_NO    = 3'd0,
        DT_BYTE  = 3'd1,
        DT_HALF  = 3'd2,
        DT_WORD  = 3'd3,
        DT_UBYTE = 3'd4,
        DT_UHALF = 3'd5
    } data_type_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_e;

    state_e              state_q, state_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [3:0]          mem_strb_q, mem_strb_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    data_type_e          type_q, type_d;
    logic [1:0]          off_q, off_d;
    logic                ld_en_q, ld_en_d;
    logic                wb_en_q, wb_en_d;
    logic [4:0]          wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;

    logic                mem_op;
    logic [ADDR_W-1:0]   req_addr;
    data_type_e          req_dt;
    logic                req_is_byte, req_is_half;
    logic [1:0]          req_off;
    logic [3:0]          req_strb;
    logic [DATA_W-1:0]   req_wdata;
    logic [7:0]          ld_byte;
    logic [15:0]         ld_half;
    logic [DATA_W-1:0]   ld_data;

    assign mem_op   = w_mem_enable_i | r_mem_enable_i;
    assign req_addr = w_mem_enable_i ? w_mem_addr_i : r_mem_addr_i;

    always_comb begin
        req_dt = DT_WORD;
        case (data_type_i)
            DT_BYTE, DT_HALF, DT_UBYTE, DT_UHALF: req_dt = data_type_e'(data_type_i);
            default:                              req_dt = DT_WORD;
        endcase
    end

    assign req_is_byte = (req_dt == DT_BYTE) || (req_dt == DT_UBYTE);
    assign req_is_half = (req_dt == DT_HALF) || (req_dt == DT_UHALF);

    // Offset is always forced to natural alignment; with the trap enabled a
    // misaligned access never reaches the port, so this only matters without it.
    always_comb begin
        if (req_is_byte) begin
            req_off   = req_addr[1:0];
            req_strb  = 4'b0001 << req_off;
            req_wdata = {4{w_mem_data_i[7:0]}};
        end else if (req_is_half) begin
            req_off   = {req_addr[1], 1'b0};
            req_strb  = 4'b0011 << req_off;
            req_wdata = {2{w_mem_data_i[15:0]}};
        end else begin
            req_off   = 2'b00;
            req_strb  = 4'b1111;
            req_wdata = w_mem_data_i;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic req_misalign;
    logic misalign_q, misalign_d;

    assign req_misalign = (req_is_half && req_addr[0]) ||
                          (!req_is_byte && !req_is_half && (req_addr[1:0] != 2'b00));
    assign misalign_o   = misalign_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign_q <= 1'b0;
        else        misalign_q <= misalign_d;
    end
`else
    assign misalign_o = 1'b0;
`endif

    always_comb begin
        case (off_q)
            2'd0:    ld_byte = mem_rdata_i[7:0];
            2'd1:    ld_byte = mem_rdata_i[15:8];
            2'd2:    ld_byte = mem_rdata_i[23:16];
            default: ld_byte = mem_rdata_i[31:24];
        endcase
        ld_half = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (type_q)
            DT_BYTE:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            DT_UBYTE: ld_data = {24'd0, ld_byte};
            DT_HALF:  ld_data = {{16{ld_half[15]}}, ld_half};
            DT_UHALF: ld_data = {16'd0, ld_half};
            default:  ld_data = mem_rdata_i;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        stall_o     = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_strb_d  = mem_strb_q;
        mem_wdata_d = mem_wdata_q;
        type_d      = type_q;
        off_d       = off_q;
        ld_en_d     = ld_en_q;
        wb_en_d     = wb_en_q;
        wb_addr_d   = wb_addr_q;
        wb_data_d   = wb_data_q;
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (mem_op) begin
                    stall_o   = 1'b1;
                    wb_en_d   = 1'b0;
                    wb_addr_d = w_reg_addr_i;
                    type_d    = req_dt;
                    off_d     = req_off;
                    ld_en_d   = mem_w_reg_enable_i & ~w_mem_enable_i;
`ifdef LSU_MISALIGN_TRAP_EN
                    if (req_misalign) begin
                        misalign_d = 1'b1;
                        state_d    = S_RESP;
                    end else
`endif
                    begin
                        state_d     = S_BUSY;
                        mem_we_d    = w_mem_enable_i;
                        mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
                        mem_strb_d  = w_mem_enable_i ? req_strb : '0;
                        mem_wdata_d = w_mem_enable_i ? req_wdata : '0;
                    end
                end else begin
                    wb_en_d   = ex_w_reg_enable_i;
                    wb_addr_d = w_reg_addr_i;
                    wb_data_d = ex_w_reg_data_i;
                end
            end
            S_BUSY: begin
                stall_o = 1'b1;
                if (mem_ack_i) begin
                    state_d = S_RESP;
                    wb_en_d = ld_en_q;
                    if (!mem_we_q) wb_data_d = ld_data;
                end
            end
            default: begin
                // Upstream still presents the finished op here; it must not be re-accepted.
                state_d = S_IDLE;
                wb_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_strb_q  <= '0;
            mem_wdata_q <= '0;
            type_q      <= DT_WORD;
            off_q       <= '0;
            ld_en_q     <= 1'b0;
            wb_en_q     <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_strb_q  <= mem_strb_d;
            mem_wdata_q <= mem_wdata_d;
            type_q      <= type_d;
            off_q       <= off_d;
            ld_en_q     <= ld_en_d;
            wb_en_q     <= wb_en_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
        end
    end

    assign mem_req_o      = (state_q == S_BUSY);
    assign mem_we_o       = mem_we_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_wstrb_o    = mem_strb_q;
    assign mem_wdata_o    = mem_wdata_q;
    assign w_reg_enable_o = wb_en_q;
    assign w_reg_addr_o   = wb_addr_q;
    assign w_reg_data_o   = wb_data_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: stimulus pushes expected memory requests and writebacks,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_lsu;

    localparam logic [2:0] T_NO    = 3'd0;
    localparam logic [2:0] T_BYTE  = 3'd1;
    localparam logic [2:0] T_HALF  = 3'd2;
    localparam logic [2:0] T_WORD  = 3'd3;
    localparam logic [2:0] T_UBYTE = 3'd4;
    localparam logic [2:0] T_UHALF = 3'd5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_w_reg_enable_i, mem_w_reg_enable_i;
    logic [4:0]  w_reg_addr_i;
    logic [31:0] ex_w_reg_data_i;
    logic        r_mem_enable_i, w_mem_enable_i;
    logic [31:0] r_mem_addr_i, w_mem_addr_i, w_mem_data_i;
    logic [2:0]  data_type_i;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        w_reg_enable_o;
    logic [4:0]  w_reg_addr_o;
    logic [31:0] w_reg_data_o;
    logic        stall_o, misalign_o;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_t;

    req_t req_q[$];
    wb_t  wb_q[$];
    int   checks = 0;
    int   errors = 0;

    lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_w_reg_enable_i(ex_w_reg_enable_i), .mem_w_reg_enable_i(mem_w_reg_enable_i),
        .w_reg_addr_i(w_reg_addr_i), .ex_w_reg_data_i(ex_w_reg_data_i),
        .r_mem_enable_i(r_mem_enable_i), .r_mem_addr_i(r_mem_addr_i),
        .w_mem_enable_i(w_mem_enable_i), .w_mem_addr_i(w_mem_addr_i), .w_mem_data_i(w_mem_data_i),
        .data_type_i(data_type_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wstrb_o(mem_wstrb_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .w_reg_enable_o(w_reg_enable_o), .w_reg_addr_o(w_reg_addr_o), .w_reg_data_o(w_reg_data_o),
        .stall_o(stall_o), .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, expected to have finished", $time);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        req_t re;
        wb_t  we;
        if (rst_n) begin
            if (w_reg_enable_o) begin
                if (wb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wb_unexpected: got reg %0d data 0x%08h, expected no writeback",
                             w_reg_addr_o, w_reg_data_o);
                end else begin
                    we = wb_q.pop_front();
                    check("wb_addr", {27'd0, w_reg_addr_o}, {27'd0, we.addr});
                    check("wb_data", w_reg_data_o, we.data);
                end
            end
            if (mem_req_o) begin
                if (req_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL req_unexpected: got addr 0x%08h we %0b, expected no request",
                             mem_addr_o, mem_we_o);
                end else begin
                    re = req_q[0];
                    check("req_we", {31'd0, mem_we_o}, {31'd0, re.we});
                    check("req_addr", mem_addr_o, re.addr);
                    check("req_strb", {28'd0, mem_wstrb_o}, {28'd0, re.strb});
                    check("req_wdata", mem_wdata_o, re.wdata);
                    if (mem_ack_i) void'(req_q.pop_front());
                end
            end
`ifndef LSU_MISALIGN_TRAP_EN
            check("misalign_tied", {31'd0, misalign_o}, 32'd0);
`endif
        end
    end

    task automatic idle_inputs();
        ex_w_reg_enable_i  = 1'b0;
        mem_w_reg_enable_i = 1'b0;
        w_reg_addr_i       = '0;
        ex_w_reg_data_i    = '0;
        r_mem_enable_i     = 1'b0;
        r_mem_addr_i       = '0;
        w_mem_enable_i     = 1'b0;
        w_mem_addr_i       = '0;
        w_mem_data_i       = '0;
        data_type_i        = T_NO;
    endtask

    task automatic alu(input logic en, input logic [4:0] r, input logic [31:0] d);
        wb_t e;
        idle_inputs();
        ex_w_reg_enable_i = en;
        w_reg_addr_i      = r;
        ex_w_reg_data_i   = d;
        if (en) begin
            e.addr = r;
            e.data = d;
            wb_q.push_back(e);
        end
        #1 check("alu_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic mem(input logic wr, input logic rd, input logic [31:0] addr,
                       input logic [31:0] wdat, input logic [2:0] dt, input logic wen,
                       input logic [4:0] r, input int busy, input logic [31:0] rdat,
                       input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                       input logic [31:0] exp_wdata, input logic [31:0] exp_wb);
        req_t q;
        wb_t  e;
        idle_inputs();
        w_mem_enable_i     = wr;
        r_mem_enable_i     = rd;
        w_mem_addr_i       = addr;
        r_mem_addr_i       = wr ? 32'h0000_0200 : addr;
        w_mem_data_i       = wdat;
        data_type_i        = dt;
        mem_w_reg_enable_i = wen;
        w_reg_addr_i       = r;
        q.we    = wr;
        q.addr  = exp_addr;
        q.strb  = exp_strb;
        q.wdata = exp_wdata;
        req_q.push_back(q);
        if (!wr && wen) begin
            e.addr = r;
            e.data = exp_wb;
            wb_q.push_back(e);
        end
        #1 check("accept_stall", {31'd0, stall_o}, 32'd1);
        @(posedge clk); #1;
        for (int b = 1; b <= busy; b++) begin
            check("busy_req", {31'd0, mem_req_o}, 32'd1);
            check("busy_stall", {31'd0, stall_o}, 32'd1);
            if (b == busy) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = rdat;
            end
            @(posedge clk); #1;
            mem_ack_i = 1'b0;
        end
        check("resp_stall", {31'd0, stall_o}, 32'd0);
        check("resp_req", {31'd0, mem_req_o}, 32'd0);
        check("resp_wb_en", {31'd0, w_reg_enable_o}, {31'd0, (!wr && wen)});
        @(posedge clk); #1;
        idle_inputs();
    endtask

    initial begin
        req_t q;
        idle_inputs();
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        #1;
        check("rst_req", {31'd0, mem_req_o}, 32'd0);
        check("rst_we", {31'd0, mem_we_o}, 32'd0);
        check("rst_addr", mem_addr_o, 32'd0);
        check("rst_strb", {28'd0, mem_wstrb_o}, 32'd0);
        check("rst_wdata", mem_wdata_o, 32'd0);
        check("rst_wb_en", {31'd0, w_reg_enable_o}, 32'd0);
        check("rst_wb_addr", {27'd0, w_reg_addr_o}, 32'd0);
        check("rst_wb_data", w_reg_data_o, 32'd0);
        check("rst_misalign", {31'd0, misalign_o}, 32'd0);
        check("rst_stall", {31'd0, stall_o}, 32'd0);
        #11 rst_n = 1'b1;
        @(posedge clk); #1;

        alu(1'b1, 5'd5, 32'h0000_1234);
        alu(1'b0, 5'd6, 32'h0000_5555);
        //  wr    rd    addr          wdata         type     wen   reg  busy rdata         exp_addr      strb     exp_wdata     exp_wb
        mem(1'b1, 1'b0, 32'h0000_0103, 32'h0000_00AB, T_BYTE,  1'b0, 5'd0,  3, 32'hFFFF_FFFF, 32'h0000_0100, 4'b1000, 32'hABAB_ABAB, 32'h0);
        mem(1'b0, 1'b1, 32'h0000_0102, 32'h0,         T_BYTE,  1'b1, 5'd7,  1, 32'h0080_0000, 32'h0000_0100, 4'b0000, 32'h0,         32'hFFFF_FF80);
        mem(1'b0, 1'b1, 32'h0000_0102, 32'h0,         T_UBYTE, 1'b1, 5'd8,  1, 32'h0080_0000, 32'h0000_0100, 4'b0000, 32'h0,         32'h0000_0080);
        mem(1'b1, 1'b0, 32'h0000_0102, 32'h1234_BEEF, T_HALF,  1'b0, 5'd0,  2, 32'hFFFF_FFFF, 32'h0000_0100, 4'b1100, 32'hBEEF_BEEF, 32'h0);
        mem(1'b0, 1'b1, 32'h0000_0100, 32'h0,         T_HALF,  1'b1, 5'd9,  1, 32'h1234_8001, 32'h0000_0100, 4'b0000, 32'h0,         32'hFFFF_8001);
        mem(1'b0, 1'b1, 32'h0000_0102, 32'h0,         T_UHALF, 1'b1, 5'd10, 2, 32'h9ABC_0000, 32'h0000_0100, 4'b0000, 32'h0,         32'h0000_9ABC);
        mem(1'b0, 1'b1, 32'h0000_0104, 32'h0,         T_WORD,  1'b1, 5'd11, 1, 32'hDEAD_BEEF, 32'h0000_0104, 4'b0000, 32'h0,         32'hDEAD_BEEF);
        mem(1'b1, 1'b0, 32'h0000_0108, 32'hCAFE_F00D, T_NO,    1'b0, 5'd0,  1, 32'hFFFF_FFFF, 32'h0000_0108, 4'b1111, 32'hCAFE_F00D, 32'h0);
        mem(1'b1, 1'b1, 32'h0000_010C, 32'h1122_3344, T_WORD,  1'b1, 5'd12, 1, 32'h0,         32'h0000_010C, 4'b1111, 32'h1122_3344, 32'h0);
        mem(1'b0, 1'b1, 32'h0000_0110, 32'h0,         T_WORD,  1'b1, 5'd13, 1, 32'h0BAD_F00D, 32'h0000_0110, 4'b0000, 32'h0,         32'h0BAD_F00D);
        mem(1'b0, 1'b1, 32'h0000_0114, 32'h0,         T_BYTE,  1'b0, 5'd14, 1, 32'h0000_007F, 32'h0000_0114, 4'b0000, 32'h0,         32'h0);

`ifdef LSU_MISALIGN_TRAP_EN
        idle_inputs();
        r_mem_enable_i     = 1'b1;
        r_mem_addr_i       = 32'h0000_0102;
        data_type_i        = T_WORD;
        mem_w_reg_enable_i = 1'b1;
        w_reg_addr_i       = 5'd15;
        #1 check("trap_accept_stall", {31'd0, stall_o}, 32'd1);
        @(posedge clk); #1;
        check("trap_pulse", {31'd0, misalign_o}, 32'd1);
        check("trap_no_req", {31'd0, mem_req_o}, 32'd0);
        check("trap_wb_en", {31'd0, w_reg_enable_o}, 32'd0);
        check("trap_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        check("trap_pulse_end", {31'd0, misalign_o}, 32'd0);
        idle_inputs();
`else
        mem(1'b0, 1'b1, 32'h0000_0102, 32'h0,         T_WORD,  1'b1, 5'd15, 1, 32'h5566_7788, 32'h0000_0100, 4'b0000, 32'h0,         32'h5566_7788);
        mem(1'b0, 1'b1, 32'h0000_0103, 32'h0,         T_UHALF, 1'b1, 5'd16, 1, 32'hAABB_CCDD, 32'h0000_0100, 4'b0000, 32'h0,         32'h0000_AABB);
`endif

        idle_inputs();
        r_mem_enable_i     = 1'b1;
        r_mem_addr_i       = 32'h0000_0120;
        data_type_i        = T_WORD;
        mem_w_reg_enable_i = 1'b1;
        w_reg_addr_i       = 5'd20;
        q.we    = 1'b0;
        q.addr  = 32'h0000_0120;
        q.strb  = 4'b0000;
        q.wdata = 32'h0;
        req_q.push_back(q);
        @(posedge clk); #1;
        check("rst_busy_req", {31'd0, mem_req_o}, 32'd1);
        #2 rst_n = 1'b0;
        idle_inputs();
        #1;
        check("rst_req_drop", {31'd0, mem_req_o}, 32'd0);
        check("rst_busy_stall", {31'd0, stall_o}, 32'd0);
        req_q.delete();
        @(posedge clk); #1;
        rst_n       = 1'b1;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        mem_ack_i = 1'b0;
        check("late_ack_wb_en", {31'd0, w_reg_enable_o}, 32'd0);
        check("late_ack_req", {31'd0, mem_req_o}, 32'd0);
        @(posedge clk); #1;
        check("late_ack_wb_en2", {31'd0, w_reg_enable_o}, 32'd0);

        alu(1'b1, 5'd31, 32'hA5A5_A5A5);
        idle_inputs();
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("wb_queue_drained", wb_q.size(), 32'd0);
        check("req_queue_drained", req_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
